// File: rtl/prbs_checker.sv
// Serial PRBS error checker: self-syncs to a Fibonacci LFSR stream,
// locks, then free-runs a local reference and counts bit errors.
module prbs_checker #(
   parameter int             N        = 3,
   parameter logic [N-1:0]   TAPS     = 3'b011,
   parameter int             LOCK_CNT = 16,
   parameter int             LOSS_CNT = 4,
   parameter int             CW       = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          din_valid,
   input  logic          din,
   output logic          locked,
   output logic          err_pulse,
   output logic [CW-1:0] err_count,
   output logic [CW-1:0] bit_count
);

   localparam int FW = $clog2(N + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
   localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_SYNC,
      ST_LOCKED
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  sr;
   logic [N-1:0]  sr_shift;
   logic [FW-1:0] fill_cnt;
   logic [MW-1:0] match_cnt;
   logic [LW-1:0] miss_cnt;

   logic pred;
   logic hit;
   logic sync_hit;
   logic fill_done;
   logic lock_hit;
   logic loss_hit;
   logic shift_in;
   logic is_fill;
   logic is_sync;
   logic is_lock;

   assign is_fill = (state == ST_FILL);
   assign is_sync = (state == ST_SYNC);
   assign is_lock = (state == ST_LOCKED);

   assign pred      = ^(sr & TAPS);
   assign hit       = (din == pred);
   // an all-zero register predicts zeros forever, so it never counts as a match
   assign sync_hit  = hit && (sr != '0);
   assign fill_done = (fill_cnt == FILL_LAST);
   assign lock_hit  = sync_hit && (match_cnt == LOCK_LAST);
   assign loss_hit  = !hit && (miss_cnt == LOSS_LAST);

   // once locked the reference free-runs on its own prediction
   assign shift_in = is_lock ? pred : din;
   assign sr_shift = N'({shift_in, sr} >> 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_FILL;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (din_valid) begin
         unique case (1'b1)
            is_fill: if (fill_done) state_next = ST_SYNC;
            is_sync: if (lock_hit)  state_next = ST_LOCKED;
            is_lock: if (loss_hit)  state_next = ST_FILL;
            default: state_next = ST_FILL;
         endcase
      end
   end

   always_comb begin
      locked = is_lock;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr        <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= din_valid && is_lock && !hit;
         if (din_valid) begin
            sr <= sr_shift;
            unique case (1'b1)
               is_fill: begin
                  fill_cnt <= fill_done ? '0 : fill_cnt + FW'(1);
               end
               is_sync: begin
                  match_cnt <= (!sync_hit || lock_hit) ? '0
                             : match_cnt + MW'(1);
                  if (lock_hit) miss_cnt <= '0;
               end
               is_lock: begin
                  miss_cnt <= (hit || loss_hit) ? '0
                            : miss_cnt + LW'(1);
                  if (loss_hit) begin
                     fill_cnt  <= '0;
                     match_cnt <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
         bit_count <= '0;
      end else if (clear) begin
         err_count <= '0;
         bit_count <= '0;
      end else if (din_valid && is_lock) begin
         if (bit_count != '1) bit_count <= bit_count + CW'(1);
         if (!hit && err_count != '1) err_count <= err_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, errors, loss/relock,
// zero stream, valid gaps, clear, async reset and saturation.
module tb_prbs_checker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        din_valid;
   logic        din;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [15:0] bit_count;
   logic        locked4;
   logic        err_pulse4;
   logic [3:0]  err_count4;
   logic [3:0]  bit_count4;

   int          checks = 0;
   int          errors = 0;
   int          pidx   = 0;
   int          pulses = 0;
   logic [6:0]  pat;

   always #5 clk = ~clk;

   prbs_checker dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .bit_count (bit_count)
   );

   prbs_checker #(.CW(4)) dut4 (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked4),
      .err_pulse (err_pulse4),
      .err_count (err_count4),
      .bit_count (bit_count4)
   );

   task automatic beat(input logic b, input logic v, input logic c);
      din       = b;
      din_valid = v;
      clear     = c;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      clear     = 1'b0;
   endtask

   // one valid beat of the generator sequence, optionally inverted
   task automatic send(input logic flip, input logic c);
      logic b;
      b    = pat[pidx] ^ flip;
      pidx = (pidx + 1) % 7;
      beat(b, 1'b1, c);
      if (err_pulse) pulses++;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      din_valid = 1'b0;
      clear     = 1'b0;
      din       = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      pidx    = 0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      din_valid = 1'b0;
      clear     = 1'b0;
      din       = 1'b0;
      #2;
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL rst_locked: got %b want 0", locked);
      end
      checks++;
      if (err_pulse !== 1'b0) begin
         errors++; $display("FAIL rst_pulse: got %b want 0", err_pulse);
      end
      checks++;
      if (err_count !== 16'd0) begin
         errors++; $display("FAIL rst_err: got %0d want 0", err_count);
      end
      checks++;
      if (bit_count !== 16'd0) begin
         errors++; $display("FAIL rst_bits: got %0d want 0", bit_count);
      end
   endtask

   task automatic test_clean_lock();
      do_reset();
      repeat (18) send(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL lock_early: got %b want 0", locked);
      end
      send(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL lock_rise: got %b want 1", locked);
      end
      pulses = 0;
      repeat (100) send(1'b0, 1'b0);
      checks++;
      if (err_count !== 16'd0) begin
         errors++; $display("FAIL clean_err: got %0d want 0", err_count);
      end
      checks++;
      if (bit_count !== 16'd100) begin
         errors++; $display("FAIL clean_bits: got %0d want 100", bit_count);
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL clean_pulses: got %0d want 0", pulses);
      end
   endtask

   task automatic test_single_flip();
      pulses = 0;
      send(1'b1, 1'b0);
      checks++;
      if (err_pulse !== 1'b1) begin
         errors++; $display("FAIL flip_pulse: got %b want 1", err_pulse);
      end
      checks++;
      if (bit_count !== 16'd101) begin
         errors++; $display("FAIL flip_bits: got %0d want 101", bit_count);
      end
      repeat (20) send(1'b0, 1'b0);
      checks++;
      if (pulses !== 1) begin
         errors++; $display("FAIL flip_pulses: got %0d want 1", pulses);
      end
      checks++;
      if (err_count !== 16'd1) begin
         errors++; $display("FAIL flip_err: got %0d want 1", err_count);
      end
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL flip_locked: got %b want 1", locked);
      end
   endtask

   task automatic test_three_flips();
      pulses = 0;
      repeat (3) send(1'b1, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL three_locked: got %b want 1", locked);
      end
      repeat (10) send(1'b0, 1'b0);
      checks++;
      if (err_count !== 16'd4) begin
         errors++; $display("FAIL three_err: got %0d want 4", err_count);
      end
      checks++;
      if (pulses !== 3 || locked !== 1'b1) begin
         errors++;
         $display("FAIL three_after: got pulses %0d locked %b want 3 1",
                  pulses, locked);
      end
   endtask

   task automatic test_loss_relock();
      pulses = 0;
      repeat (3) send(1'b1, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL loss_early: got %b want 1", locked);
      end
      send(1'b1, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL loss_fall: got %b want 0", locked);
      end
      checks++;
      if (err_count !== 16'd8 || pulses !== 4) begin
         errors++;
         $display("FAIL loss_err: got err %0d pulses %0d want 8 4",
                  err_count, pulses);
      end
      repeat (18) send(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL relock_early: got %b want 0", locked);
      end
      send(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL relock_rise: got %b want 1", locked);
      end
      checks++;
      if (err_count !== 16'd8) begin
         errors++; $display("FAIL relock_err: got %0d want 8", err_count);
      end
   endtask

   task automatic test_saturation();
      repeat (8) begin
         send(1'b1, 1'b0);
         repeat (3) send(1'b0, 1'b0);
      end
      checks++;
      if (err_count !== 16'd16) begin
         errors++; $display("FAIL sat_err16: got %0d want 16", err_count);
      end
      checks++;
      if (err_count4 !== 4'd15) begin
         errors++; $display("FAIL sat_err4: got %0d want 15", err_count4);
      end
      checks++;
      if (bit_count4 !== 4'd15) begin
         errors++; $display("FAIL sat_bits4: got %0d want 15", bit_count4);
      end
   endtask

   task automatic test_clear();
      send(1'b1, 1'b1);
      checks++;
      if (err_pulse !== 1'b1) begin
         errors++; $display("FAIL clr_pulse: got %b want 1", err_pulse);
      end
      checks++;
      if (err_count !== 16'd0 || bit_count !== 16'd0) begin
         errors++;
         $display("FAIL clr_counts: got %0d %0d want 0 0",
                  err_count, bit_count);
      end
      checks++;
      if (err_count4 !== 4'd0 || locked !== 1'b1) begin
         errors++;
         $display("FAIL clr_keep: got err4 %0d locked %b want 0 1",
                  err_count4, locked);
      end
      send(1'b0, 1'b0);
      checks++;
      if (bit_count !== 16'd1) begin
         errors++; $display("FAIL clr_resume: got %0d want 1", bit_count);
      end
   endtask

   task automatic test_reset_mid_lock();
      send(1'b1, 1'b0);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (locked !== 1'b0 || err_count !== 16'd0 || bit_count !== 16'd0) begin
         errors++;
         $display("FAIL async_rst: got %b %0d %0d want 0 0 0",
                  locked, err_count, bit_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (18) send(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL rst_relock_early: got %b want 0", locked);
      end
      send(1'b0, 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++; $display("FAIL rst_relock: got %b want 1", locked);
      end
   endtask

   task automatic test_zero_stream();
      int seen;
      seen = 0;
      do_reset();
      repeat (200) begin
         beat(1'b0, 1'b1, 1'b0);
         if (locked) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL zero_lock: got %0d want 0", seen);
      end
      checks++;
      if (err_count !== 16'd0 || bit_count !== 16'd0) begin
         errors++;
         $display("FAIL zero_counts: got %0d %0d want 0 0",
                  err_count, bit_count);
      end
   endtask

   task automatic test_valid_gaps();
      int n;
      int idle_pulse;
      n          = 0;
      idle_pulse = 0;
      pulses     = 0;
      do_reset();
      for (int i = 0; i < 2000 && n < 119; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            n++;
            if (n == 19) pulses = 0;
            send((n == 69) ? 1'b1 : 1'b0, 1'b0);
            if (n == 18) begin
               checks++;
               if (locked !== 1'b0) begin
                  errors++; $display("FAIL gap_early: got %b want 0", locked);
               end
            end
            if (n == 19) begin
               checks++;
               if (locked !== 1'b1) begin
                  errors++; $display("FAIL gap_lock: got %b want 1", locked);
               end
            end
         end else begin
            beat(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (err_pulse) idle_pulse++;
         end
      end
      checks++;
      if (n !== 119) begin
         errors++; $display("FAIL gap_budget: got %0d beats want 119", n);
      end
      checks++;
      if (err_count !== 16'd1 || bit_count !== 16'd100) begin
         errors++;
         $display("FAIL gap_counts: got %0d %0d want 1 100",
                  err_count, bit_count);
      end
      checks++;
      if (pulses !== 1 || idle_pulse !== 0) begin
         errors++;
         $display("FAIL gap_pulses: got %0d idle %0d want 1 0",
                  pulses, idle_pulse);
      end
   endtask

   initial begin
      pat = 7'b1101001;
      test_reset();
      test_clean_lock();
      test_single_flip();
      test_three_flips();
      test_loss_relock();
      test_saturation();
      test_clear();
      test_reset_mid_lock();
      test_zero_stream();
      test_valid_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
